flt_ar_seq: RTL



---
 rtl/flt_ar_pkg.sv | 45 ++++
 rtl/flt_ar_seq_if.sv | 19 +
 rtl/flt_ar_unpack.sv | 35 +++
 rtl/flt_ar_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/flt_ar_pkg.sv
// Shared definitions for the binary64 add/sub/neg sequencer: op encodings,
// field widths, canonical constants, FSM states and operand payloads.
package flt_ar_pkg;

  localparam int unsigned WORDSIZE = 64;
  localparam int unsigned EXP_W    = 11;
  localparam int unsigned FRAC_W   = 52;
  localparam int unsigned BIAS     = 1023;
  localparam int unsigned MANT_W   = FRAC_W + 1;   // hidden bit restored
  localparam int unsigned ALN_W    = MANT_W + 3;   // plus guard/round/sticky
  localparam int unsigned SUM_W    = ALN_W + 1;    // plus carry
  localparam int unsigned RND_W    = MANT_W + 1;
  localparam int unsigned EXPR_W   = EXP_W + 1;
  localparam int unsigned EXP_MAX  = 2 * BIAS + 1;

  localparam logic [5:0] op_flt_ar_add = 6'b01_0000;
  localparam logic [5:0] op_flt_ar_sub = 6'b01_0001;
  localparam logic [5:0] op_flt_ar_neg = 6'b01_0010;

  localparam logic [WORDSIZE-1:0] QNAN    = 64'h7FF8_0000_0000_0000;
  localparam logic [WORDSIZE-1:0] INF_POS = 64'h7FF0_0000_0000_0000;
  localparam logic [WORDSIZE-1:0] INF_NEG = 64'hFFF0_0000_0000_0000;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              zero;
  } fp_op_t;

  typedef struct packed {
    fp_op_t v;
    logic   inf;
    logic   nan;
  } fp_unpacked_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic illegal_op;
  } flags_t;

endpackage

// File: rtl/flt_ar_seq_if.sv
// Request/result handshake bundle between the ALU decoder and the FP sequencer.
interface flt_ar_seq_if;
  import flt_ar_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [WORDSIZE-1:0] input_a;
  logic [WORDSIZE-1:0] input_b;
  logic [5:0]          operation;
  logic                out_valid;
  logic                out_ready;
  logic [WORDSIZE-1:0] out;
  flags_t              out_flags;

  modport master (output in_valid, input_a, input_b, operation, out_ready,
                  input  in_ready, out_valid, out, out_flags);
  modport slave  (input  in_valid, input_a, input_b, operation, out_ready,
                  output in_ready, out_valid, out, out_flags);
endinterface

// File: rtl/flt_ar_unpack.sv
// Splits both binary64 operands into sign/exp/mantissa, flushes subnormals
// to signed zero and classifies inf/NaN.
module flt_ar_unpack
  import flt_ar_pkg::*;
(
  input  logic [WORDSIZE-1:0] a,
  input  logic [WORDSIZE-1:0] b,
  output fp_unpacked_t        ua,
  output fp_unpacked_t        ub
);

  function automatic fp_unpacked_t unpack(input logic [WORDSIZE-1:0] x);
    fp_unpacked_t     u;
    logic [EXP_W-1:0] e;
    logic             frac_nz;
    e         = x[WORDSIZE-2 -: EXP_W];
    frac_nz   = |x[FRAC_W-1:0];
    u.v.sign  = x[WORDSIZE-1];
    u.v.exp   = e;
    u.v.mant  = {1'b1, x[FRAC_W-1:0]};
    u.v.zero  = 1'b0;
    u.inf     = (e == '1) && !frac_nz;
    u.nan     = (e == '1) && frac_nz;
    if (e == '0) begin
      u.v.exp  = '0;
      u.v.mant = '0;
      u.v.zero = 1'b1;
    end
    return u;
  endfunction

  assign ua = unpack(a);
  assign ub = unpack(b);

endmodule

// File: rtl/flt_ar_seq.sv
// Multi-cycle binary64 add/sub/neg sequencer: specials resolve in IDLE,
// everything else walks ALIGN -> ADD -> NORM (iterative) -> ROUND -> DONE.
module flt_ar_seq
  import flt_ar_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  flt_ar_seq_if.slave bus
);

  state_t              state, state_n;
  fp_unpacked_t        ua, ub;
  fp_op_t              opa, opa_n, opb, opb_n;
  logic                sign_r, sign_n;
  logic                eff_sub, eff_sub_n;
  logic [EXPR_W-1:0]   exp_r, exp_n;
  logic [ALN_W-1:0]    man_l, man_l_n, man_s, man_s_n;
  logic [SUM_W-1:0]    sum_r, sum_n;
  logic                in_ready_r, in_ready_n;
  logic                out_valid_r, out_valid_n;
  logic [WORDSIZE-1:0] out_r, out_n;
  flags_t              flags_r, flags_n;
  logic [WORDSIZE-1:0] b_eff;

  // sub is add with b's sign inverted
  assign b_eff = {bus.input_b[WORDSIZE-1] ^ (bus.operation == op_flt_ar_sub),
                  bus.input_b[WORDSIZE-2:0]};

  flt_ar_unpack u_unpack (.a(bus.input_a), .b(b_eff), .ua(ua), .ub(ub));

  // Alignment: larger magnitude first, smaller shifted with sticky collapse
  logic              a_big, big_sign, sm_zero;
  logic [EXP_W-1:0]  big_exp, sm_exp, ediff;
  logic [MANT_W-1:0] big_mant, sm_mant;
  logic [ALN_W-1:0]  sm_full, sm_mask, sm_shr, sm_aligned;

  assign a_big    = {opa.exp, opa.mant} >= {opb.exp, opb.mant};
  assign big_sign = a_big ? opa.sign : opb.sign;
  assign big_exp  = a_big ? opa.exp  : opb.exp;
  assign big_mant = a_big ? opa.mant : opb.mant;
  assign sm_exp   = a_big ? opb.exp  : opa.exp;
  assign sm_mant  = a_big ? opb.mant : opa.mant;
  assign sm_zero  = a_big ? opb.zero : opa.zero;
  assign ediff    = big_exp - sm_exp;
  assign sm_full  = {sm_mant, 3'b000};
  assign sm_mask  = (ALN_W'(1) << ediff) - ALN_W'(1);
  assign sm_shr   = sm_full >> ediff;
  assign sm_aligned = (ediff >= EXP_W'(ALN_W))
                    ? {{(ALN_W-1){1'b0}}, ~sm_zero}
                    : {sm_shr[ALN_W-1:1], sm_shr[0] | (|(sm_full & sm_mask))};

  // Round to nearest even on guard/round/sticky
  logic              rnd_up;
  logic [RND_W-1:0]  mant_rnd;
  logic [EXPR_W-1:0] exp_rnd;
  logic [FRAC_W-1:0] frac_rnd;

  assign rnd_up   = sum_r[2] & (sum_r[1] | sum_r[0] | sum_r[3]);
  assign mant_rnd = {1'b0, sum_r[ALN_W-1:3]} + RND_W'(rnd_up);
  assign exp_rnd  = exp_r + EXPR_W'(mant_rnd[MANT_W]);
  assign frac_rnd = mant_rnd[MANT_W] ? mant_rnd[MANT_W-1:1] : mant_rnd[MANT_W-2:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      opa         <= '0;
      opb         <= '0;
      sign_r      <= 1'b0;
      eff_sub     <= 1'b0;
      exp_r       <= '0;
      man_l       <= '0;
      man_s       <= '0;
      sum_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_r       <= '0;
      flags_r     <= '0;
    end else begin
      state       <= state_n;
      opa         <= opa_n;
      opb         <= opb_n;
      sign_r      <= sign_n;
      eff_sub     <= eff_sub_n;
      exp_r       <= exp_n;
      man_l       <= man_l_n;
      man_s       <= man_s_n;
      sum_r       <= sum_n;
      in_ready_r  <= in_ready_n;
      out_valid_r <= out_valid_n;
      out_r       <= out_n;
      flags_r     <= flags_n;
    end
  end

  always_comb begin
    state_n   = state;
    opa_n     = opa;
    opb_n     = opb;
    sign_n    = sign_r;
    eff_sub_n = eff_sub;
    exp_n     = exp_r;
    man_l_n   = man_l;
    man_s_n   = man_s;
    sum_n     = sum_r;
    out_n     = out_r;
    flags_n   = flags_r;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          opa_n   = ua.v;
          opb_n   = ub.v;
          out_n   = '0;
          flags_n = '0;
          state_n = DONE;
          if (bus.operation == op_flt_ar_neg) begin
            out_n = {~bus.input_a[WORDSIZE-1], bus.input_a[WORDSIZE-2:0]};
          end else if (bus.operation != op_flt_ar_add && bus.operation != op_flt_ar_sub) begin
            flags_n.illegal_op = 1'b1;
          end else if (ua.nan || ub.nan) begin
            out_n = QNAN;
          end else if (ua.inf && ub.inf && (ua.v.sign != ub.v.sign)) begin
            out_n           = QNAN;
            flags_n.invalid = 1'b1;
          end else if (ua.inf) begin
            out_n = bus.input_a;
          end else if (ub.inf) begin
            out_n = b_eff;
          end else begin
            state_n = ALIGN;
          end
        end
      end
      ALIGN: begin
        sign_n    = big_sign;
        eff_sub_n = opa.sign ^ opb.sign;
        exp_n     = {1'b0, big_exp};
        man_l_n   = {big_mant, 3'b000};
        man_s_n   = sm_aligned;
        state_n   = ADD;
      end
      ADD: begin
        sum_n   = eff_sub ? ({1'b0, man_l} - {1'b0, man_s})
                          : ({1'b0, man_l} + {1'b0, man_s});
        state_n = NORM;
      end
      NORM: begin
        if (sum_r[SUM_W-1]) begin
          sum_n   = {1'b0, sum_r[SUM_W-1:2], sum_r[1] | sum_r[0]};
          exp_n   = exp_r + EXPR_W'(1);
          state_n = ROUND;
        end else if (sum_r == '0) begin
          out_n   = '0;
          state_n = DONE;
        end else if (sum_r[ALN_W-1]) begin
          state_n = ROUND;
        end else begin
          // one-bit left shift per cycle; exponent underflow flushes to zero
          sum_n = sum_r << 1;
          exp_n = exp_r - EXPR_W'(1);
          if (exp_r == EXPR_W'(1)) begin
            out_n   = {sign_r, {(WORDSIZE-1){1'b0}}};
            state_n = DONE;
          end else if (sum_r[ALN_W-2]) begin
            state_n = ROUND;
          end
        end
      end
      ROUND: begin
        state_n = DONE;
        if (exp_rnd >= EXPR_W'(EXP_MAX)) begin
          out_n            = sign_r ? INF_NEG : INF_POS;
          flags_n.overflow = 1'b1;
        end else begin
          out_n = {sign_r, exp_rnd[EXP_W-1:0], frac_rnd};
        end
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    in_ready_n  = (state_n == IDLE);
    out_valid_n = (state_n == DONE);
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out       = out_r;
  assign bus.out_flags = flags_r;

endmodule
